// File: rtl/result_streamer_if.sv
// result_streamer_if
//   Bundles the two handshakes of the result streamer:
//     capture side : cap_valid / cap_data / cap_ready  (multiplier -> streamer)
//     output side  : out_valid / out_ready / out_data / out_idx / out_last
//                    (streamer -> host read port)
//   modport slave  : the streamer's view (takes results, produces words)
//   modport master : the surrounding system's view (offers results, consumes words)
interface result_streamer_if #(
  parameter int dw = 31,
  parameter int rw = 256
);
  logic          cap_valid;
  logic [rw-1:0] cap_data;
  logic          cap_ready;
  logic          out_valid;
  logic          out_ready;
  logic [dw:0]   out_data;
  logic [2:0]    out_idx;
  logic          out_last;

  modport master (
    output cap_valid, cap_data, out_ready,
    input  cap_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  cap_valid, cap_data, out_ready,
    output cap_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/result_streamer.sv
// result_streamer
//   Captures 256-bit matrix-multiplier results into a 2-entry ping-pong
//   buffer and drains each one as eight 32-bit words, LSB word first, over a
//   valid/ready stream. A second result can be captured while the first is
//   still being read out.
//
// Ports
//   clk       rising-edge clock
//   n_reset   asynchronous active-low reset
//   clear     synchronous flush of buffer, word index and overflow flag
//   bus       result_streamer_if.slave (capture and output handshakes)
//   busy      buffer non-empty (same as out_valid)
//   overflow  sticky: a result was offered while the buffer was full
//
// state     | meaning
// ----------+-------------------------------------------------------
// st_empty  | count == 0, nothing to stream, out_valid low
// st_stream | count >= 1, head entry is being streamed word by word
module result_streamer #(
  parameter int dw     = 31,
  parameter int rw     = 256,
  parameter int nwords = 8
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               clear,
  result_streamer_if.slave   bus,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic {
    st_empty  = 1'b0,
    st_stream = 1'b1
  } state_t;

  localparam logic [2:0] last_idx = 3'(nwords - 1);

  state_t     state, state_nxt;
  logic [1:0] count, count_nxt;
  logic       wr_ptr, wr_ptr_nxt;
  logic       rd_ptr, rd_ptr_nxt;
  logic [2:0] idx, idx_nxt;
  logic       overflow_nxt;

  logic [rw-1:0] entry [2];

  logic out_valid;
  logic cap_fire;
  logic pop_word;
  logic pop_last;

  // cap_ready depends only on registered count, never on out_ready, so a
  // full buffer blocks capture even in a cycle where the head is popped.
  assign bus.cap_ready = (count != 2'd2);
  assign out_valid     = (state == st_stream);
  assign bus.out_valid = out_valid;
  assign busy          = out_valid;

  assign cap_fire = bus.cap_valid && bus.cap_ready && !clear;
  assign pop_word = out_valid && bus.out_ready;
  assign pop_last = pop_word && (idx == last_idx);

  // Entry contents are never reset; gating with out_valid keeps the data
  // output at zero whenever the buffer is empty (including during reset).
  assign bus.out_data = out_valid ? entry[rd_ptr][(dw+1)*idx +: dw+1] : '0;
  assign bus.out_idx  = idx;
  assign bus.out_last = out_valid && (idx == last_idx);

  always_ff @(posedge clk) begin
    if (cap_fire) begin
      entry[wr_ptr] <= bus.cap_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= st_empty;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      idx      <= 3'd0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      idx      <= idx_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    idx_nxt      = idx;
    overflow_nxt = overflow;

    if (clear) begin
      state_nxt    = st_empty;
      count_nxt    = 2'd0;
      wr_ptr_nxt   = 1'b0;
      rd_ptr_nxt   = 1'b0;
      idx_nxt      = 3'd0;
      overflow_nxt = 1'b0;
    end else begin
      if (bus.cap_valid && !bus.cap_ready) begin
        overflow_nxt = 1'b1;
      end

      if (cap_fire) begin
        wr_ptr_nxt = ~wr_ptr;
      end

      if (pop_word) begin
        if (idx == last_idx) begin
          idx_nxt    = 3'd0;
          rd_ptr_nxt = ~rd_ptr;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end

      // Capture and final-word pop in the same cycle cancel out on count.
      case ({cap_fire, pop_last})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase

      case (state)
        st_empty: begin
          if (cap_fire) begin
            state_nxt = st_stream;
          end
        end
        st_stream: begin
          if (pop_last && !cap_fire && (count == 2'd1)) begin
            state_nxt = st_empty;
          end
        end
        default: state_nxt = st_empty;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
module tb_result_streamer;

  logic clk = 1'b0;
  logic n_reset;
  logic clear;
  logic busy;
  logic overflow;

  result_streamer_if #(.dw(31), .rw(256)) bus ();

  result_streamer #(.dw(31), .rw(256), .nwords(8)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .clear    (clear),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: a queue of whole results plus the word position in the head.
  logic [255:0] mq [$];
  int           widx;
  bit           movf;

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic reset_model();
    mq.delete();
    widx = 0;
    movf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    logic [255:0] head;
    logic [31:0]  wexp;
    bit           v;
    v    = (mq.size() != 0);
    head = v ? mq[0] : '0;
    wexp = v ? head[widx*32 +: 32] : 32'h0;
    chk({ph, " out_valid"}, 256'(bus.out_valid), 256'(v));
    chk({ph, " out_data"},  256'(bus.out_data),  256'(wexp));
    chk({ph, " out_idx"},   256'(bus.out_idx),   256'(widx));
    chk({ph, " out_last"},  256'(bus.out_last),  256'(v && widx == 7));
    chk({ph, " cap_ready"}, 256'(bus.cap_ready), 256'(mq.size() < 2));
    chk({ph, " busy"},      256'(busy),          256'(v));
    chk({ph, " overflow"},  256'(overflow),      256'(movf));
  endtask

  // Applies the rules of one rising edge to the reference, using the inputs
  // that were held across that edge.
  task automatic model_edge();
    int sz;
    sz = mq.size();
    if (!n_reset) begin
      reset_model();
    end else if (clear) begin
      reset_model();
    end else begin
      if (bus.cap_valid && sz == 2) movf = 1'b1;
      if (sz != 0 && bus.out_ready) begin
        if (widx == 7) begin
          void'(mq.pop_front());
          widx = 0;
        end else begin
          widx++;
        end
      end
      if (bus.cap_valid && sz < 2) mq.push_back(bus.cap_data);
    end
  endtask

  task automatic tick(input string ph);
    check_outputs(ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    bit will_accept;

    n_reset       = 1'b0;
    clear         = 1'b0;
    bus.cap_valid = 1'b0;
    bus.cap_data  = '0;
    bus.out_ready = 1'b0;
    reset_model();
    @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    n_reset = 1'b1;

    // single result, consumer always ready
    bus.cap_data  = mk(32'h1000_0000);
    bus.cap_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick("single");
    bus.cap_valid = 1'b0;
    repeat (10) tick("single");

    // backpressure with ready pattern 1,0,0,1,0,0,...
    bus.cap_valid = 1'b1;
    tick("bp");
    bus.cap_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.out_ready = (i % 3 == 0);
      tick("bp");
    end

    // fill both entries, then offer a third result
    bus.out_ready = 1'b0;
    bus.cap_valid = 1'b1;
    bus.cap_data  = mk(32'hA000_0000);
    tick("full");
    bus.cap_data  = mk(32'hB000_0000);
    tick("full");
    bus.cap_data  = mk(32'hC000_0000);
    repeat (2) tick("full_ovf");
    bus.cap_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (18) tick("full_drain");
    clear = 1'b1;
    tick("full_clr");
    clear = 1'b0;

    // capture in the same cycle as the final-word pop
    bus.cap_valid = 1'b1;
    bus.cap_data  = mk(32'hC0DE_0000);
    tick("cop");
    bus.cap_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (widx == 7 && mq.size() == 1) begin
        bus.cap_valid = 1'b1;
        bus.cap_data  = mk(32'hD000_0000);
        tick("cop_pop");
        bus.cap_valid = 1'b0;
        hit = 1'b1;
      end else begin
        tick("cop");
      end
    end
    chk("cop_reached_word7", 256'(hit), 256'(1));
    repeat (10) tick("cop_drain");

    // clear mid-stream after word 3 while a capture is offered
    bus.cap_valid = 1'b1;
    bus.cap_data  = mk(32'hE000_0000);
    tick("clr");
    bus.cap_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (widx == 4) hit = 1'b1;
      else tick("clr");
    end
    chk("clr_reached_word4", 256'(hit), 256'(1));
    bus.cap_valid = 1'b1;
    bus.cap_data  = mk(32'hF000_0000);
    clear = 1'b1;
    tick("clr_edge");
    clear = 1'b0;
    bus.cap_valid = 1'b0;
    repeat (4) tick("clr_after");

    // asynchronous reset between clock edges
    bus.cap_valid = 1'b1;
    bus.cap_data  = mk(32'h5000_0000);
    tick("arst");
    bus.cap_valid = 1'b0;
    repeat (3) tick("arst");
    bus.out_ready = 1'b0;
    #2 n_reset = 1'b0;
    #1 reset_model();
    check_outputs("arst_imm");
    @(negedge clk);
    n_reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.cap_valid = 1'b1;
    bus.cap_data  = mk(32'h6000_0000);
    tick("arst_new");
    bus.cap_valid = 1'b0;
    repeat (10) tick("arst_new");

    // randomized traffic; producer holds an offer until it is accepted
    bus.cap_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom % 4) != 0;
      clear         = ($urandom % 60) == 0;
      will_accept   = bus.cap_valid && mq.size() < 2 && !clear;
      tick("rand");
      if (will_accept || !bus.cap_valid) begin
        bus.cap_valid = ($urandom % 3) == 0;
        bus.cap_data  = rnd256();
      end
    end
    clear = 1'b0;
    bus.cap_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) tick("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Sits directly downstream of the matrix multiplier and consumes its 256-bit result vector.
- Captures results into a 2-entry ping-pong buffer.
- Drains each result as eight 32-bit words, LSB word first, over a valid/ready stream toward the host read port.
- Decouples multiplier completion from host readout, so a second calculation can finish while the first result is still being read.

Parameters:
- dw, 31, MSB index of the output word; word width is dw+1.
- rw, 256, result vector width; must equal 8*(dw+1).
- nwords, 8, words per result (rw/(dw+1)).

Ports:
- clk  input  1  rising-edge clock
- n_reset  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of buffer and word index
- cap_valid  input  1  multiplier result available
- cap_data  input  rw  multiplier result vector
- cap_ready  output  1  buffer can accept a result
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer accepts word
- out_data  output  dw+1  current result word
- out_idx  output  3  index (0..7) of current word within its result
- out_last  output  1  high with word 7
- busy  output  1  buffer non-empty
- overflow  output  1  sticky: cap_valid seen while cap_ready low

Behaviour:
- Reset (n_reset low, async): buffer count=0, wr_ptr=0, rd_ptr=0, word index=0, overflow=0. All outputs read 0 except cap_ready=1.
- Storage: two rw-bit entries, 1-bit wr_ptr and rd_ptr, 2-bit count (0..2).
- cap_ready = (count != 2). It is registered-state derived only, with no combinational dependence on out_ready.
- Capture: on cap_valid && cap_ready at edge T, entry[wr_ptr] <= cap_data, wr_ptr toggles, count increments.
  - If buffer was empty, out_valid=1 from T+1 (1-cycle latency); there is no bypass from cap_data to out_data.
- State machine (derived from count): EMPTY (count=0), STREAM (count>=1). EMPTY->STREAM on capture; STREAM->EMPTY when last word of last entry is accepted with no same-cycle capture.
- out_valid = (count != 0).
- out_data = entry[rd_ptr][32*idx +: 32]; out_idx = idx; out_last = out_valid && idx==7.
- Word handshake: a word transfers when out_valid && out_ready.
  - Transfer with idx<7: idx increments.
  - Transfer with idx==7: idx <= 0, rd_ptr toggles, count decrements.
- Hold: while out_valid && !out_ready, out_data/out_idx/out_last are stable.
- Simultaneous capture and final-word pop in the same cycle: count unchanged, both pointers advance.
  - At count=2, capture is blocked even if a pop occurs that cycle.
  - out_valid stays high across the entry boundary with no bubble; the next word is idx 0 of the new entry.
- overflow: set on any edge with cap_valid && !cap_ready; cleared only by clear or reset. The offered result is not stored, and the producer holds cap_valid until accepted.
- clear: synchronous, priority over capture and pop. Next edge sets count=0, pointers=0, idx=0, overflow=0; a capture offered in the same cycle is discarded and does not set overflow.
- busy = out_valid.
- Reset mid-stream: all state lost, out_valid drops immediately (async), the partial result is discarded.
- Entry contents are not cleared on reset or clear; they are don't-care while count=0.

Test Plan:
- Single result: cap_data with word k = 32'h1000_0000+k, out_ready=1 -> out_valid at T+1; eight consecutive words 0x10000000..0x10000007; out_last only on word 7; out_valid low the cycle after; busy mirrors out_valid.
- Backpressure: same result, out_ready toggled 1,0,0,1,... -> each word held stable while ready low; no word skipped or duplicated; idx sequence 0..7.
- Double buffer full: capture R0 (words 0xA..), then R1 (words 0xB..) with out_ready=0 -> count=2, cap_ready=0. A third cap_valid sets overflow=1. Draining yields R0 then R1 with no gap at the boundary.
- Capture-on-pop: count=1, cap_valid during acceptance of word 7 -> capture accepted, count stays 1, next word is idx 0 of new result, out_valid never drops.
- clear mid-stream after word 3 with cap_valid high -> next cycle out_valid=0, overflow=0, cap_ready=1, the offered result is not stored.
- Async reset asserted mid-word with no clk edge -> outputs zero immediately, cap_ready=1. After release, a new capture streams from idx 0.
